cam_frame_grabber: RTL
======================

Name: cam_frame_grabber

Overview:
- Parametrised successor to the camera read path.
- Arms the AL422 FIFO on OV vsync and captures exactly one frame into the FIFO.
- Reads the frame back with a generated rclk and packs bytes into 32-bit words.
- Writes the words to SRAM through a req/ack port owned by the memory arbiter, with optional double buffering and continuous mode so the VGA side always scans a complete frame.

Parameters:
H_RES, 320, pixels per line
V_RES, 240, lines per frame
BYTES_PER_PIX, 2, 1 or 2; H_RES*V_RES*BYTES_PER_PIX must be a multiple of 4
ADDR_W, 20, SRAM word address width
BASE_ADDR, 0, word address of buffer 0
DOUBLE_BUF, 1, 1 = two buffers (buffer 1 at BASE_ADDR+FRAME_WORDS), 0 = single buffer
RST_CYC, 4, low-pulse length, in clk cycles, of fifo_wrst and in rclk periods of fifo_rrst

Ports:
clk  in  1  system clock (qu_clk domain)
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse; begins capture from IDLE
continuous  in  1  1 = re-arm automatically after each frame
abort  in  1  synchronous; return to IDLE
cam_data  in  8  FIFO read data
ov_vsync  in  1  camera vsync, asynchronous
rclk  out  1  FIFO read clock
fifo_wen  out  1  FIFO write enable
fifo_wrst  out  1  FIFO write-pointer reset, active-low
fifo_rrst  out  1  FIFO read-pointer reset, active-low
fifo_oe  out  1  FIFO output enable, active-low
wr_req  out  1  SRAM write request
wr_addr  out  ADDR_W  SRAM word address
wr_data  out  32  SRAM write data
wr_ack  in  1  one-cycle accept from arbiter
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse per completed frame
front_buf  out  1  buffer VGA should scan
frame_cnt  out  8  completed frames, wraps at 255

Behaviour:
- FRAME_BYTES = H_RES*V_RES*BYTES_PER_PIX; FRAME_WORDS = FRAME_BYTES/4.
- Reset values: rclk 0, fifo_wen 0, fifo_wrst 1, fifo_rrst 1, fifo_oe 1, wr_req 0, wr_addr BASE_ADDR, wr_data 0, busy 0, frame_done 0, front_buf 0, frame_cnt 0.
- Reset asserted mid-operation forces all of the above immediately; any pending wr_req is dropped.
- ov_vsync passes through a 2-flop synchroniser plus an edge register. A rising edge (vs_rise) is seen 3 clk cycles after the pin changes.
- IDLE: start -> ARM.
- ARM: vs_rise -> WRST.
- WRST: fifo_wrst=0 and fifo_wen=1 for RST_CYC cycles -> CAPTURE.
- CAPTURE: fifo_wen=1 until the next vs_rise, then fifo_wen=0 on that cycle -> RRST.
- RRST: fifo_oe=0, fifo_rrst=0 while rclk toggles for RST_CYC periods. Then fifo_rrst=1; byte counter, word counter and shift register cleared -> READ.
- READ: fifo_oe=0; rclk toggles 1 then 0 (one rclk period = 2 clk).
  - cam_data is sampled on the clk edge where rclk goes 1->0.
  - Bytes pack little-endian: first byte to wr_data[7:0].
  - On the 4th byte of a word, wr_data is loaded and wr_req=1; rclk holds 0 until wr_ack.
  - wr_addr, wr_data and wr_req are stable while wr_req=1 and ack is absent.
  - wr_ack lowers wr_req the next cycle and increments wr_addr. Reading resumes the cycle after ack.
  - After the ack of word FRAME_WORDS-1 -> DONE.
- DONE (1 cycle): frame_done=1, frame_cnt+1, front_buf toggles if DOUBLE_BUF=1. Then -> ARM if continuous else IDLE.
- Write target is the back buffer: base = BASE_ADDR + (DOUBLE_BUF ? !front_buf : 0)*FRAME_WORDS.
  - wr_addr is reloaded to this base on entry to RRST.
  - front_buf changes only in DONE, never mid-frame.
- vs_rise in RRST, READ or DONE is ignored. The frame in flight completes; the next capture waits for a fresh vsync in ARM.
- start outside IDLE is ignored. Dropping continuous mid-frame finishes the current frame, then -> IDLE.
- abort in any state -> IDLE next cycle:
  - wr_req=0, fifo_wen=0, fifo_wrst=1, fifo_rrst=1, fifo_oe=1, rclk=0.
  - No frame_done; front_buf and frame_cnt unchanged.
  - wr_ack arriving on the abort cycle is ignored.
- abort and start in the same cycle: abort wins.

Test Plan:
Use H_RES=4, V_RES=2, BYTES_PER_PIX=2, BASE_ADDR=0x100 (FRAME_BYTES=16, FRAME_WORDS=4) for all scenarios.
1. Reset, start, vsync pulse -> fifo_wrst low exactly 4 cycles starting 4 cycles after the pin rises, fifo_wen high until the next vsync. Then, with FIFO model bytes 0x00..0x0F and wr_ack 1 cycle after each req: wr_data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C at addr 0x104..0x107 (back buffer 1). frame_done pulses once, front_buf=1, frame_cnt=1, busy=0.
2. continuous=1, three frames -> write bases 0x104, 0x100, 0x104; front_buf 1,0,1; frame_cnt=3.
3. wr_ack delayed 5 cycles on word 2 -> rclk held 0, wr_addr/wr_data stable for 5 cycles, no byte lost; data identical to scenario 1.
4. Extra vsync pulse during READ -> ignored; frame data correct; next capture starts only on a later vsync.
5. abort after 2 words written -> IDLE next cycle, wr_req 0, no frame_done, front_buf and frame_cnt unchanged. A subsequent start captures normally to the same back buffer.
6. rst low during READ with wr_req=1 -> all outputs at reset values on the same cycle; after release, busy=0 until start.

Source files
------------

// File: rtl/cam_frame_grabber.sv
// Camera frame grabber: arms the AL422 FIFO on vsync, captures one frame, reads it
// back with a generated rclk and writes packed 32-bit words to SRAM via req/ack.
module cam_frame_grabber #(
  parameter int unsigned H_RES         = 320,
  parameter int unsigned V_RES         = 240,
  parameter int unsigned BYTES_PER_PIX = 2,
  parameter int unsigned ADDR_W        = 20,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int unsigned DOUBLE_BUF    = 1,
  parameter int unsigned RST_CYC       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic [7:0]        cam_data,
  input  logic              ov_vsync,
  output logic              rclk,
  output logic              fifo_wen,
  output logic              fifo_wrst,
  output logic              fifo_rrst,
  output logic              fifo_oe,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ack,
  output logic              busy,
  output logic              frame_done,
  output logic              front_buf,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned FRAME_BYTES = H_RES * V_RES * BYTES_PER_PIX;
  localparam int unsigned FRAME_WORDS = FRAME_BYTES / 4;
  localparam int unsigned WC_W        = $clog2(FRAME_WORDS + 1);
  localparam int unsigned CNT_W       = $clog2(2 * RST_CYC + 1);

  localparam logic [ADDR_W-1:0] BASE0     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE1     = ADDR_W'(BASE_ADDR + FRAME_WORDS);
  localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0]  WRST_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0]  RRST_LAST = CNT_W'(2 * RST_CYC - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_WRST    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RRST    = 3'd4;
  localparam logic [2:0] S_READ    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [23:0]       shift_q, shift_d;
  logic              rclk_q, rclk_d;
  logic              wen_q, wen_d;
  logic              wrst_q, wrst_d;
  logic              rrst_q, rrst_d;
  logic              oe_q, oe_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              front_q, front_d;
  logic [7:0]        fcnt_q, fcnt_d;

  logic              vs_s1_q, vs_s2_q, vs_e_q, vs_rise_q;
  logic [ADDR_W-1:0] back_base;

  // Registered edge detect adds one cycle so the FSM sees vs_rise 3 cycles after the pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_s1_q   <= 1'b0;
      vs_s2_q   <= 1'b0;
      vs_e_q    <= 1'b0;
      vs_rise_q <= 1'b0;
    end else begin
      vs_s1_q   <= ov_vsync;
      vs_s2_q   <= vs_s1_q;
      vs_e_q    <= vs_s2_q;
      vs_rise_q <= vs_s2_q & ~vs_e_q;
    end
  end

  assign back_base = ((DOUBLE_BUF != 0) && !front_q) ? BASE1 : BASE0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    shift_d = shift_q;
    rclk_d  = 1'b0;
    wen_d   = 1'b0;
    wrst_d  = 1'b1;
    rrst_d  = 1'b1;
    oe_d    = 1'b1;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    front_d = front_q;
    fcnt_d  = fcnt_q;

    if (abort) begin
      state_d = S_IDLE;
      req_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_d = S_ARM;
        end
        S_ARM: begin
          if (vs_rise_q) begin
            state_d = S_WRST;
            cnt_d   = '0;
            wrst_d  = 1'b0;
            wen_d   = 1'b1;
          end
        end
        S_WRST: begin
          wen_d = 1'b1;
          if (cnt_q == WRST_LAST) begin
            state_d = S_CAPTURE;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            wrst_d = 1'b0;
          end
        end
        S_CAPTURE: begin
          if (vs_rise_q) begin
            state_d = S_RRST;
            cnt_d   = '0;
            oe_d    = 1'b0;
            rrst_d  = 1'b0;
            addr_d  = back_base;
          end else begin
            wen_d = 1'b1;
          end
        end
        S_RRST: begin
          oe_d = 1'b0;
          if (cnt_q == RRST_LAST) begin
            state_d = S_READ;
            bcnt_d  = '0;
            wcnt_d  = '0;
            shift_d = '0;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            rrst_d = 1'b0;
            rclk_d = ~rclk_q;
          end
        end
        S_READ: begin
          oe_d = 1'b0;
          if (req_q) begin
            if (wr_ack) begin
              req_d  = 1'b0;
              addr_d = addr_q + ADDR_W'(1);
              wcnt_d = wcnt_q + WC_W'(1);
              if (wcnt_q == LAST_WORD) begin
                state_d = S_DONE;
                oe_d    = 1'b1;
                done_d  = 1'b1;
                fcnt_d  = fcnt_q + 8'd1;
                front_d = (DOUBLE_BUF != 0) ? ~front_q : front_q;
              end
            end
          end else if (!rclk_q) begin
            rclk_d = 1'b1;
          end else begin
            // rclk falls on this edge; the byte presented since the rising edge is taken now.
            shift_d = {cam_data, shift_q[23:8]};
            bcnt_d  = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              data_d = {cam_data, shift_q};
              req_d  = 1'b1;
            end
          end
        end
        S_DONE: begin
          state_d = continuous ? S_ARM : S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      shift_q <= '0;
      rclk_q  <= 1'b0;
      wen_q   <= 1'b0;
      wrst_q  <= 1'b1;
      rrst_q  <= 1'b1;
      oe_q    <= 1'b1;
      req_q   <= 1'b0;
      addr_q  <= BASE0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      front_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      shift_q <= shift_d;
      rclk_q  <= rclk_d;
      wen_q   <= wen_d;
      wrst_q  <= wrst_d;
      rrst_q  <= rrst_d;
      oe_q    <= oe_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      front_q <= front_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign rclk       = rclk_q;
  assign fifo_wen   = wen_q;
  assign fifo_wrst  = wrst_q;
  assign fifo_rrst  = rrst_q;
  assign fifo_oe    = oe_q;
  assign wr_req     = req_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign front_buf  = front_q;
  assign frame_cnt  = fcnt_q;

endmodule
